// File: rtl/seg_display_capture.sv
// Receive-side monitor for a muxed 4-digit 7-segment bus.
// Optional scroll tracking when SEG_CAPTURE_SHIFT_EN is defined.
module seg_display_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 600,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anodos,
    input  logic [7:0]  segmentos,
`ifdef SEG_CAPTURE_SHIFT_EN
    input  logic        shift,
    output logic [7:0]  shift_cnt,
`endif
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic [3:0]  blank,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        glyph_err,
    output logic        anode_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam bit ONE_SHOT = (STABLE_CYCLES <= 1);

    logic [3:0]       a_q;
    logic [7:0]       s_q;
    logic [3:0]       pa_q;
    logic [7:0]       ps_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tcnt;

    logic             onehot;
    logic             illegal;
    logic             same;
    logic             a_same;
    logic             latch;
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] tinc;
    logic [CNT_W-1:0] acnt;
    logic [3:0]       lbit;
    logic [3:0]       vnext;
    logic [6:0]       seg;
    logic [3:0]       nib;
    logic             gok;
    logic             gblank;

    always_comb begin
        onehot  = (a_q == 4'hE) || (a_q == 4'hD) ||
                  (a_q == 4'hB) || (a_q == 4'h7);
        illegal = !onehot && (a_q != 4'hF);
        same    = ({a_q, s_q} == {pa_q, ps_q});
        a_same  = (a_q == pa_q);
        inc     = (cnt >= STB) ? cnt : cnt + ONE;
        tinc    = (tcnt >= TMO) ? tcnt : tcnt + ONE;
        acnt    = a_same ? inc : ONE;
        // a changed pattern restarts the count at 1, so it can only
        // latch immediately when one stable sample is enough
        if (state == SETTLE && same)
            latch = onehot && (inc >= STB);
        else
            latch = onehot && (!same || state == IDLE) && ONE_SHOT;
        lbit = latch ? ~a_q : 4'h0;
    end

    always_comb begin
        seg = ~s_q[6:0];
        gok = 1'b1;
        nib = 4'h0;
        case (seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: gok = 1'b0;
        endcase
        gblank = (seg == 7'h00);
    end

    // a full valid mask is cleared on the following edge, newest latch included
    always_comb begin
`ifdef SEG_CAPTURE_SHIFT_EN
        if (valid == 4'hF)
            vnext = 4'h0;
        else if (shift)
            vnext = lbit;
        else
            vnext = valid | lbit;
`else
        vnext = (valid == 4'hF) ? 4'h0 : (valid | lbit);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q        <= 4'hF;
            s_q        <= 8'hFF;
            pa_q       <= 4'hF;
            ps_q       <= 8'hFF;
            state      <= IDLE;
            cnt        <= '0;
            tcnt       <= '0;
            digits     <= '0;
            dps        <= '0;
            blank      <= '0;
            valid      <= '0;
            frame_done <= 1'b0;
            glyph_err  <= 1'b0;
            anode_err  <= 1'b0;
            stall      <= 1'b0;
`ifdef SEG_CAPTURE_SHIFT_EN
            shift_cnt  <= '0;
`endif
        end else begin
            a_q        <= anodos;
            s_q        <= segmentos;
            pa_q       <= a_q;
            ps_q       <= s_q;
            tcnt       <= a_same ? tinc : '0;
            stall      <= a_same && (tinc == TMO);
            valid      <= vnext;
            frame_done <= (vnext == 4'hF);
`ifdef SEG_CAPTURE_SHIFT_EN
            if (shift)
                shift_cnt <= shift_cnt + 8'd1;
`endif
            if (latch) begin
                for (int i = 0; i < 4; i++) begin
                    if (!a_q[i]) begin
                        digits[4*i +: 4] <= nib;
                        blank[i]         <= gblank;
                        dps[i]           <= ~s_q[7];
                    end
                end
                if (!gok && !gblank)
                    glyph_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (onehot) begin
                        cnt   <= ONE;
                        state <= latch ? HOLD : SETTLE;
                    end else if (illegal) begin
                        cnt <= acnt;
                        if (acnt >= STB)
                            anode_err <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (same) begin
                        cnt <= inc;
                        if (latch)
                            state <= HOLD;
                    end else if (onehot) begin
                        cnt   <= ONE;
                        state <= latch ? HOLD : SETTLE;
                    end else begin
                        state <= IDLE;
                        cnt   <= illegal ? ONE : '0;
                        if (illegal && ONE_SHOT)
                            anode_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!same) begin
                        if (onehot) begin
                            cnt   <= ONE;
                            state <= latch ? HOLD : SETTLE;
                        end else begin
                            state <= IDLE;
                            cnt   <= illegal ? ONE : '0;
                            if (illegal && ONE_SHOT)
                                anode_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_capture.sv
// Bench for seg_display_capture: directed steps plus random traffic
// scored against a run-length model of the capture rules.
module tb_seg_display_capture;

    localparam int S = 4;
    localparam int T = 600;
    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [3:0] ILL [6] = '{4'hC, 4'hA, 4'h9, 4'h6, 4'h5, 4'h3};
    localparam logic [3:0] DIG [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  anodos = 4'hF;
    logic [7:0]  segmentos = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic [3:0]  valid;
    logic        frame_done;
    logic        glyph_err;
    logic        anode_err;
    logic        stall;
`ifdef SEG_CAPTURE_SHIFT_EN
    logic        shift = 1'b0;
    logic [7:0]  shift_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int fd_seen = 0;

    // model: newest registered sample, its run lengths, expected outputs
    logic [3:0]  ca;
    logic [7:0]  cs;
    int          run_a;
    int          run_f;
    logic [15:0] m_dig;
    logic [3:0]  m_dps;
    logic [3:0]  m_blank;
    logic [3:0]  m_valid;
    logic        m_fd;
    logic        m_gerr;
    logic        m_aerr;
    logic        m_stall;
    logic [7:0]  m_scnt;

    always #5 clk = ~clk;

    seg_display_capture dut (
        .clk        (clk),
        .rst        (rst),
        .anodos     (anodos),
        .segmentos  (segmentos),
`ifdef SEG_CAPTURE_SHIFT_EN
        .shift      (shift),
        .shift_cnt  (shift_cnt),
`endif
        .digits     (digits),
        .dps        (dps),
        .blank      (blank),
        .valid      (valid),
        .frame_done (frame_done),
        .glyph_err  (glyph_err),
        .anode_err  (anode_err),
        .stall      (stall)
    );

    function automatic bit is_dig(input logic [3:0] a);
        return (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
    endfunction

    function automatic int didx(input logic [3:0] a);
        for (int k = 0; k < 4; k++)
            if (!a[k]) return k;
        return 0;
    endfunction

    function automatic logic [4:0] mdec(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (GL[k] == p) return {1'b1, 4'(k)};
        return 5'h00;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] lb;
        logic [4:0] g;
        logic       sh;
        int         d;
        @(posedge clk);
        sh = 1'b0;
`ifdef SEG_CAPTURE_SHIFT_EN
        sh = shift;
`endif
        if (!rst) begin
            m_dig = '0; m_dps = '0; m_blank = '0; m_valid = '0;
            m_fd = 1'b0; m_gerr = 1'b0; m_aerr = 1'b0;
            m_stall = 1'b0; m_scnt = '0;
            ca = 4'hF; cs = 8'hFF; run_a = 2; run_f = 2;
        end else begin
            lb = 4'h0;
            if (is_dig(ca) && run_f == S) begin
                d = didx(ca);
                lb[d] = 1'b1;
                g = mdec(~cs[6:0]);
                m_dig[4*d +: 4] = g[3:0];
                m_blank[d] = (cs[6:0] == 7'h7F);
                m_dps[d] = ~cs[7];
                if (!g[4] && cs[6:0] != 7'h7F) m_gerr = 1'b1;
            end
            if (!is_dig(ca) && ca != 4'hF && run_a >= S) m_aerr = 1'b1;
            m_stall = (run_a - 1 >= T);
            if (m_valid == 4'hF) begin
                m_valid = 4'h0;
                m_fd = 1'b0;
            end else begin
                m_valid = sh ? lb : (m_valid | lb);
                m_fd = (m_valid == 4'hF);
            end
            if (sh) m_scnt++;
            run_a = (anodos == ca) ? run_a + 1 : 1;
            run_f = (anodos == ca && segmentos == cs) ? run_f + 1 : 1;
            ca = anodos;
            cs = segmentos;
        end
        #1;
        if (frame_done) fd_seen++;
        check("outputs",
              64'({digits, dps, blank, valid, frame_done,
                   glyph_err, anode_err, stall}),
              64'({m_dig, m_dps, m_blank, m_valid, m_fd,
                   m_gerr, m_aerr, m_stall}));
`ifdef SEG_CAPTURE_SHIFT_EN
        check("shift_cnt", 64'(shift_cnt), 64'(m_scnt));
`endif
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s,
                         input int n);
        anodos = a;
        segmentos = s;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
        anodos = 4'hF;
        segmentos = 8'hFF;
    endtask

    initial begin
        int k;
        logic [3:0] ra;
        logic [7:0] rs;
        // reset with toggling inputs, then first-latch latency
        for (int i = 0; i < 3; i++) begin
            anodos = 4'($urandom);
            segmentos = 8'($urandom);
            tick();
        end
        check("reset_out",
              64'({digits, dps, blank, valid, frame_done,
                   glyph_err, anode_err, stall}), 64'h0);
        anodos = 4'hE;
        segmentos = ~8'h3F;
        rst = 1'b1;
        repeat (S) tick();
        check("lat_early", 64'(valid[0]), 64'h0);
        tick();
        check("lat_on", 64'(valid[0]), 64'h1);

        // full frame 3210
        do_reset(2);
        fd_seen = 0;
        drive(4'hE, ~8'h3F, 8);
        drive(4'hD, ~8'h06, 8);
        drive(4'hB, ~8'h5B, 8);
        drive(4'h7, ~8'h4F, 8);
        check("frame_digits", 64'(digits), 64'h3210);
        check("frame_dps", 64'(dps), 64'h0);
        check("frame_pulses", 64'(fd_seen), 64'h1);
        check("frame_valid", 64'(valid), 64'h0);

        // glitch rejection
        do_reset(2);
        drive(4'hF, 8'hFF, 2);
        drive(4'hE, ~8'h3F, 3);
        drive(4'hF, 8'hFF, 4);
        check("glitch_rej", 64'(valid), 64'h0);
        drive(4'hE, ~8'h3F, 4);
        check("glitch_c4", 64'(valid[0]), 64'h0);
        drive(4'hF, 8'hFF, 1);
        check("glitch_c5", 64'(valid[0]), 64'h1);

        // glyph and anode errors, sticky until reset
        do_reset(2);
        drive(4'hB, ~8'h5B, 8);
        check("dig2_pre", 64'(digits[11:8]), 64'h2);
        drive(4'hB, ~8'h49, 8);
        check("glyph_err", 64'(glyph_err), 64'h1);
        check("glyph_dig", 64'(digits[11:8]), 64'h0);
        drive(4'hC, 8'hFF, 4);
        check("aerr_c4", 64'(anode_err), 64'h0);
        tick();
        check("aerr_c5", 64'(anode_err), 64'h1);
        drive(4'hE, ~8'h3F, 10);
        check("sticky", 64'({glyph_err, anode_err}), 64'h3);
        do_reset(1);
        check("err_clr", 64'({glyph_err, anode_err}), 64'h0);

        // reset in the middle of settling discards the digit
        drive(4'hD, ~8'h06, 3);
        rst = 1'b0;
        repeat (2) tick();
        check("rst_discard", 64'({digits, valid}), 64'h0);
        rst = 1'b1;
        repeat (S) tick();
        check("rst_settle_early", 64'(valid[1]), 64'h0);
        tick();
        check("rst_settle_latch", 64'(valid[1]), 64'h1);

        // stall
        do_reset(1);
        drive(4'hF, 8'hFF, 3);
        anodos = 4'hB;
        segmentos = ~8'h66;
        k = 0;
        for (int i = 1; i <= T + 20; i++) begin
            tick();
            k = i;
            if (stall) break;
        end
        check("stall_rise", 64'(k), 64'(T + 2));
        anodos = 4'h7;
        tick();
        check("stall_hold", 64'(stall), 64'h1);
        tick();
        check("stall_drop", 64'(stall), 64'h0);

`ifdef SEG_CAPTURE_SHIFT_EN
        do_reset(1);
        shift = 1'b1;
        repeat (255) tick();
        check("scnt_255", 64'(shift_cnt), 64'hFF);
        tick();
        check("scnt_wrap", 64'(shift_cnt), 64'h0);
        shift = 1'b0;
        do_reset(1);
        fd_seen = 0;
        drive(4'hE, ~8'h3F, 8);
        drive(4'hD, ~8'h06, 8);
        drive(4'hB, ~8'h5B, 8);
        check("pre_shift", 64'(valid), 64'h7);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        check("shift_clr", 64'(valid), 64'h0);
        drive(4'h7, ~8'h4F, 8);
        check("no_frame", 64'(fd_seen), 64'h0);
        check("post_shift_v", 64'(valid), 64'h8);
        drive(4'hE, ~8'h3F, 8);
        drive(4'hD, ~8'h06, 8);
        drive(4'hB, ~8'h5B, 8);
        check("post_frame", 64'(fd_seen), 64'h1);
`endif

        // random traffic against the model
        do_reset(2);
        for (int i = 0; i < 160; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7) ra = DIG[k % 4];
            else if (k == 7) ra = 4'hF;
            else ra = ILL[$urandom_range(0, 5)];
            k = $urandom_range(0, 9);
            if (k < 7) rs = {1'($urandom), ~GL[$urandom_range(0, 15)]};
            else if (k == 7) rs = {1'($urandom), 7'h7F};
            else rs = 8'($urandom);
            anodos = ra;
            segmentos = rs;
            k = $urandom_range(1, 9);
            for (int j = 0; j < k; j++) begin
`ifdef SEG_CAPTURE_SHIFT_EN
                shift = ($urandom_range(0, 15) == 0);
`endif
                tick();
            end
            if (i == 80) do_reset(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
